// File: rtl/input_pkg.sv
// Shared definitions for the player-button conditioner: channel indices and
// the per-channel press/auto-repeat state encoding.
package input_pkg;

    // Channel order matches the game core's {left,down,rotate,right} op bus.
    localparam int unsigned BTN_RIGHT   = 0;
    localparam int unsigned BTN_ROTATE  = 1;
    localparam int unsigned BTN_DOWN    = 2;
    localparam int unsigned BTN_LEFT    = 3;
    localparam int unsigned BTN_RESTART = 4;

    localparam int unsigned REP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, tick-based debounce, press/auto-repeat FSM and a
// sticky event flag cleared by the consumer's acknowledge.
module btn_channel
    import input_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 300,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    input  logic ack_i,
    output logic level_o,
    output logic pulse_o,
    output logic event_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);

    logic                 sync1_q, sync2_q;
    logic                 level_q, level_d;
    logic [DW-1:0]        db_cnt_q, db_cnt_d;
    btn_state_e           state_q, state_d;
    logic [REP_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                 pulse_q, pulse_d;
    logic                 event_q, event_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            pulse_q   <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            sync1_q   <= raw_i ^ ACTIVE_LOW;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            pulse_q   <= pulse_d;
            event_q   <= event_d;
        end
    end

    always_comb begin
        level_d   = level_q;
        db_cnt_d  = db_cnt_q;
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pulse_d   = 1'b0;
        // A new pulse outranks an acknowledge arriving in the same cycle.
        event_d   = pulse_q | (event_q & ~ack_i);

        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (db_cnt_q == DW'(DEBOUNCE_MS - 1)) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (level_q) begin
                    state_d   = DELAY;
                    rep_cnt_d = '0;
                    pulse_d   = 1'b1;
                end
            end
            DELAY: begin
                if (!level_q) begin
                    state_d = IDLE;
                end else if (REPEAT_EN && tick_i) begin
                    if (rep_cnt_q == REP_CNT_W'(REPEAT_DELAY_MS - 1)) begin
                        state_d   = REPEAT;
                        rep_cnt_d = '0;
                        pulse_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!level_q) begin
                    state_d = IDLE;
                end else if (tick_i) begin
                    if (rep_cnt_q == REP_CNT_W'(REPEAT_RATE_MS - 1)) begin
                        rep_cnt_d = '0;
                        pulse_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign event_o = event_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw player buttons: one shared 1 ms tick prescaler feeding
// N_BTN independent btn_channel instances.
module input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned          N_BTN           = 5,
    parameter int unsigned          CLK_HZ          = 50_000_000,
    parameter int unsigned          DEBOUNCE_MS     = 20,
    parameter int unsigned          REPEAT_DELAY_MS = 300,
    parameter int unsigned          REPEAT_RATE_MS  = 100,
    parameter logic [N_BTN-1:0]     REPEAT_MASK     = 5'b01101,
    parameter bit                   ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw_i,
    input  logic [N_BTN-1:0] ack_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] pulse_o,
    output logic [N_BTN-1:0] event_o
);

    localparam int unsigned PRESC = CLK_HZ / 1000;
    localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_comb begin
        tick_c  = (presc_q == PW'(PRESC - 1));
        presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_EN       (REPEAT_MASK[g]),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick_c),
            .raw_i   (btn_raw_i[g]),
            .ack_i   (ack_i[g]),
            .level_o (level_o[g]),
            .pulse_o (pulse_o[g]),
            .event_o (event_o[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a behavioural
// model built from held-tick arithmetic rather than a state machine.
module tb_input_conditioner;
    import input_pkg::*;

    localparam int N      = 5;
    localparam int CLK_HZ = 4000;
    localparam int DB     = 3;
    localparam int RD     = 10;
    localparam int RR     = 5;
    localparam int PRESC  = CLK_HZ / 1000;
    localparam logic [N-1:0] MASK = 5'b01101;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] ack     = '0;
    logic [N-1:0] level, pulse, evt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    input_conditioner #(
        .N_BTN           (N),
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_MS     (DB),
        .REPEAT_DELAY_MS (RD),
        .REPEAT_RATE_MS  (RR),
        .REPEAT_MASK     (MASK),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw_i (btn_raw),
        .ack_i     (ack),
        .level_o   (level),
        .pulse_o   (pulse),
        .event_o   (evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: level from consecutive disagreeing ticks; pulses from the
    // number of ticks the accepted level has been held.
    logic [N-1:0] m_level, m_pulse, m_event, m_sync1, m_sync2, m_rise;
    int           m_dcnt [N];
    int           m_held [N];
    int           m_pc;
    logic         m_tick, m_s, m_nxt;

    always @(posedge clk) begin
        if (reset) begin
            m_level = '0; m_pulse = '0; m_event = '0;
            m_sync1 = '0; m_sync2 = '0; m_rise = '0;
            m_pc = 0;
            for (int i = 0; i < N; i++) begin
                m_dcnt[i] = 0;
                m_held[i] = 0;
            end
        end else begin
            m_tick = (m_pc == PRESC - 1);
            m_pc   = m_tick ? 0 : m_pc + 1;
            for (int i = 0; i < N; i++) begin
                m_nxt    = m_rise[i];
                m_rise[i] = 1'b0;
                if (m_level[i] && m_tick) begin
                    m_held[i]++;
                    if (MASK[i] && m_held[i] >= RD && (m_held[i] - RD) % RR == 0)
                        m_nxt = 1'b1;
                end
                m_s        = m_sync2[i];
                m_sync2[i] = m_sync1[i];
                m_sync1[i] = btn_raw[i];
                if (m_s == m_level[i]) begin
                    m_dcnt[i] = 0;
                end else if (m_tick) begin
                    m_dcnt[i]++;
                    if (m_dcnt[i] == DB) begin
                        m_level[i] = ~m_level[i];
                        m_dcnt[i]  = 0;
                        if (m_level[i]) begin
                            m_rise[i] = 1'b1;
                            m_held[i] = 0;
                        end
                    end
                end
                m_event[i] = m_pulse[i] | (m_event[i] & ~ack[i]);
                m_pulse[i] = m_nxt;
            end
        end
    end

    task automatic test_reset();
        btn_raw = '0;
        ack     = '0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 5'b0) begin
            errors++;
            $display("FAIL reset_level got=%b want=00000", level);
        end
        checks++;
        if (pulse !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulse got=%b want=00000", pulse);
        end
        checks++;
        if (evt !== 5'b0) begin
            errors++;
            $display("FAIL reset_event got=%b want=00000", evt);
        end
        reset = 1'b0;
    endtask

    task automatic test_left_repeat();
        int rise = -1;
        int pt[$];
        int exp_off[5] = '{1, 40, 60, 80, 100};
        btn_raw[BTN_LEFT] = 1'b1;
        for (int c = 0; c < 170; c++) begin
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL left_hold cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (rise < 0 && m_level[BTN_LEFT]) rise = cyc;
            if (pulse[BTN_LEFT]) pt.push_back(cyc);
            if (c == 110) btn_raw[BTN_LEFT] = 1'b0;
        end
        checks++;
        if (pt.size() != 5) begin
            errors++;
            $display("FAIL left_pulse_count got=%0d want=5", pt.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (pt[k] - rise != exp_off[k]) begin
                    errors++;
                    $display("FAIL left_pulse_offset k=%0d got=%0d want=%0d",
                             k, pt[k] - rise, exp_off[k]);
                end
            end
        end
    endtask

    task automatic test_rotate_no_repeat();
        int np = 0;
        btn_raw[BTN_ROTATE] = 1'b1;
        for (int c = 0; c < 170; c++) begin
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL rotate_hold cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (pulse[BTN_ROTATE]) np++;
            if (c == 110) btn_raw[BTN_ROTATE] = 1'b0;
        end
        checks++;
        if (np != 1) begin
            errors++;
            $display("FAIL rotate_pulse_count got=%0d want=1", np);
        end
    endtask

    task automatic test_glitch();
        int nl = 0;
        int np = 0;
        for (int c = 0; c < 100; c++) begin
            btn_raw[BTN_DOWN] = (c < 80) && ((c / PRESC) % 3 != 2);
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL glitch cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (level[BTN_DOWN]) nl++;
            if (pulse[BTN_DOWN]) np++;
        end
        checks++;
        if (nl != 0 || np != 0) begin
            errors++;
            $display("FAIL glitch_down got level_cycles=%0d pulses=%0d want 0 and 0", nl, np);
        end
    endtask

    task automatic test_event_ack();
        bit seen = 0;
        ack = '1;
        @(negedge clk);
        ack = '0;
        btn_raw[BTN_RIGHT] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL event_first cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (c == 30) btn_raw[BTN_RIGHT] = 1'b0;
        end
        checks++;
        if (evt[BTN_RIGHT] !== 1'b1) begin
            errors++;
            $display("FAIL event_sticky got=%b want=1", evt[BTN_RIGHT]);
        end
        btn_raw[BTN_RIGHT] = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL event_second cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (m_pulse[BTN_RIGHT]) begin
                seen = 1;
                ack[BTN_RIGHT] = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL event_second_pulse got=none want=pulse within 40 cycles");
        end else begin
            @(negedge clk);
            checks++;
            if (evt[BTN_RIGHT] !== 1'b1) begin
                errors++;
                $display("FAIL event_ack_same_cycle got=%b want=1", evt[BTN_RIGHT]);
            end
            @(negedge clk);
            checks++;
            if (evt[BTN_RIGHT] !== 1'b0) begin
                errors++;
                $display("FAIL event_ack_clear got=%b want=0", evt[BTN_RIGHT]);
            end
        end
        ack = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 20) btn_raw[BTN_RIGHT] = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        int tl = -1;
        int tr = -1;
        btn_raw[BTN_LEFT]  = 1'b1;
        btn_raw[BTN_RIGHT] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL simul cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (tl < 0 && pulse[BTN_LEFT])  tl = cyc;
            if (tr < 0 && pulse[BTN_RIGHT]) tr = cyc;
            if (c == 40) begin
                btn_raw[BTN_LEFT]  = 1'b0;
                btn_raw[BTN_RIGHT] = 1'b0;
            end
        end
        checks++;
        if (tl < 0 || tl != tr) begin
            errors++;
            $display("FAIL simul_same_cycle got left=%0d right=%0d want equal and present", tl, tr);
        end
    endtask

    task automatic test_reset_mid_hold();
        // Prescaler restarts at 0: s is high from cycle 3, ticks end cycles 4,8,12.
        localparam int RST_LAT = PRESC * DB + 1;
        int tp = -1;
        int np = 0;
        int waited = 0;
        btn_raw[BTN_DOWN] = 1'b1;
        while (!m_level[BTN_DOWN] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!m_level[BTN_DOWN] || level[BTN_DOWN] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_level got=%b want=1", level[BTN_DOWN]);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({level, pulse, evt} !== 15'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got l=%b p=%b e=%b want all 0", level, pulse, evt);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL rst_rehold cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
            if (pulse[BTN_DOWN]) begin
                np++;
                if (tp < 0) tp = c;
            end
            if (c == 30) btn_raw[BTN_DOWN] = 1'b0;
        end
        checks++;
        if (np != 1 || tp != RST_LAT) begin
            errors++;
            $display("FAIL rst_repress got pulses=%0d at=%0d want 1 at=%0d", np, tp, RST_LAT);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) btn_raw[i] = ~btn_raw[i];
            ack = N'($urandom & $urandom);
            @(negedge clk);
            checks++;
            if ({level, pulse, evt} !== {m_level, m_pulse, m_event}) begin
                errors++;
                $display("FAIL random cyc=%0d got l=%b p=%b e=%b want l=%b p=%b e=%b",
                         cyc, level, pulse, evt, m_level, m_pulse, m_event);
            end
        end
        btn_raw = '0;
        ack     = '0;
    endtask

    initial begin
        test_reset();
        test_left_repeat();
        test_rotate_no_repeat();
        test_glitch();
        test_event_ack();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
